// File: rtl/dcache_pkg.sv
// Shared definitions for the n-way data cache: walk FSM states and tag-field layout.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    OFFER,
    DONE
  } walk_state_e;

  // Flag bits sit directly above the TAG_W-bit address tag.
  localparam int unsigned TAG_VALID_OFS = 1;
  localparam int unsigned TAG_DIRTY_OFS = 0;

  function automatic int unsigned tag_valid_pos(input int unsigned tag_w);
    return tag_w + TAG_VALID_OFS;
  endfunction

  function automatic int unsigned tag_dirty_pos(input int unsigned tag_w);
    return tag_w + TAG_DIRTY_OFS;
  endfunction

endpackage

// File: rtl/lru_ages.sv
// True-LRU age storage for every set, with one touch/init port and victim select
// for the currently addressed set.
module lru_ages #(
  parameter int unsigned WAYS = 4,
  parameter int unsigned SETS = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [$clog2(SETS)-1:0]  set_i,
  input  logic [WAYS-1:0]          valid_i,
  input  logic                     touch_i,
  input  logic [$clog2(WAYS)-1:0]  touch_way_i,
  input  logic                     init_i,
  output logic [$clog2(WAYS)-1:0]  victim_o
);

  localparam int unsigned WAY_W = $clog2(WAYS);

  logic [WAY_W-1:0] age_q [SETS][WAYS];
  logic [WAY_W-1:0] touch_age;
  logic             found;

  assign touch_age = age_q[set_i][touch_way_i];

  always_comb begin
    victim_o = '0;
    found    = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!valid_i[w] && !found) begin
        victim_o = WAY_W'(w);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[set_i][w] == WAY_W'(WAYS - 1)) victim_o = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < SETS; s++)
        for (int unsigned w = 0; w < WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else if (init_i) begin
      for (int unsigned w = 0; w < WAYS; w++)
        age_q[set_i][w] <= WAY_W'(w);
    end else if (touch_i) begin
      // Ways younger than the touched one age by one; older ways keep their age.
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way_i)
          age_q[set_i][w] <= '0;
        else if (age_q[set_i][w] < touch_age)
          age_q[set_i][w] <= age_q[set_i][w] + WAY_W'(1);
      end
    end
  end

endmodule

// File: rtl/dcache_sram_nway.sv
// N-way set-associative data cache array with true-LRU replacement and a
// write-back-and-invalidate flush walk.
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS   = 4,
  parameter int unsigned SETS   = 16,
  parameter int unsigned TAG_W  = 23,
  parameter int unsigned LINE_W = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [$clog2(SETS)-1:0]  addr_i,
  input  logic [TAG_W+1:0]         tag_i,
  input  logic [LINE_W-1:0]        data_i,
  input  logic                     enable_i,
  input  logic                     write_i,
  output logic [TAG_W+1:0]         tag_o,
  output logic [LINE_W-1:0]        data_o,
  output logic                     hit_o,
  input  logic                     flush_i,
  output logic                     busy_o,
  output logic                     wb_valid_o,
  output logic [$clog2(SETS)-1:0]  wb_addr_o,
  output logic [TAG_W+1:0]         wb_tag_o,
  output logic [LINE_W-1:0]        wb_data_o,
  input  logic                     wb_ready_i
);

  localparam int unsigned SET_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned CUR_W = SET_W + WAY_W;
  localparam int unsigned VB    = tag_valid_pos(TAG_W);
  localparam int unsigned DB    = tag_dirty_pos(TAG_W);

  logic [TAG_W+1:0]  tag_q  [SETS][WAYS];
  logic [LINE_W-1:0] data_q [SETS][WAYS];

  walk_state_e      state_q;
  logic [CUR_W-1:0] cur_q;
  logic             busy_q;
  logic             wb_valid_q;

  logic [SET_W-1:0] cur_set;
  logic [WAY_W-1:0] cur_way;
  logic [SET_W-1:0] lru_set;
  logic [WAYS-1:0]  lru_valid;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] sel_way;
  logic             hit_any;
  logic             acc_en, acc_wr, touch;
  logic             cur_dirty, scan_clr, offer_acc, advance, last_entry, set_end;

  assign cur_set = cur_q[CUR_W-1:WAY_W];
  assign cur_way = cur_q[WAY_W-1:0];

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (tag_q[addr_i][w][VB] && (tag_q[addr_i][w][TAG_W-1:0] == tag_i[TAG_W-1:0])) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // The LRU block follows the walk cursor while busy so a finished set can be re-initialised.
  assign lru_set = busy_q ? cur_set : addr_i;

  always_comb begin
    lru_valid = '0;
    for (int unsigned w = 0; w < WAYS; w++)
      lru_valid[w] = tag_q[lru_set][w][VB];
  end

  assign sel_way = hit_any ? hit_way : victim;
  assign acc_en  = enable_i & ~busy_q;
  assign acc_wr  = acc_en & write_i;
  assign touch   = acc_en & (write_i | hit_any);

  assign cur_dirty  = tag_q[cur_set][cur_way][VB] & tag_q[cur_set][cur_way][DB];
  assign scan_clr   = (state_q == SCAN) & ~cur_dirty;
  assign offer_acc  = (state_q == OFFER) & wb_ready_i;
  assign advance    = scan_clr | offer_acc;
  assign last_entry = &cur_q;
  assign set_end    = advance & (&cur_way);

  lru_ages #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .set_i       (lru_set),
    .valid_i     (lru_valid),
    .touch_i     (touch),
    .touch_way_i (sel_way),
    .init_i      (set_end),
    .victim_o    (victim)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
        end
      end
    end else begin
      if (acc_wr) begin
        tag_q[addr_i][sel_way]  <= tag_i;
        data_q[addr_i][sel_way] <= data_i;
      end
      if (scan_clr) tag_q[cur_set][cur_way][VB] <= 1'b0;
      if (offer_acc) begin
        tag_q[cur_set][cur_way][VB] <= 1'b0;
        tag_q[cur_set][cur_way][DB] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      busy_q     <= 1'b0;
      wb_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (flush_i) begin
            state_q <= SCAN;
            cur_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (cur_dirty) begin
            state_q    <= OFFER;
            wb_valid_q <= 1'b1;
          end else begin
            cur_q   <= cur_q + CUR_W'(1);
            state_q <= last_entry ? DONE : SCAN;
          end
        end
        OFFER: begin
          if (wb_ready_i) begin
            wb_valid_q <= 1'b0;
            cur_q      <= cur_q + CUR_W'(1);
            state_q    <= last_entry ? DONE : SCAN;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hit_o      = hit_any & ~busy_q;
  assign tag_o      = tag_q[addr_i][sel_way];
  assign data_o     = data_q[addr_i][sel_way];
  assign busy_o     = busy_q;
  assign wb_valid_o = wb_valid_q;
  assign wb_addr_o  = cur_set;
  assign wb_tag_o   = tag_q[cur_set][cur_way];
  assign wb_data_o  = data_q[cur_set][cur_way];

endmodule
